reg_write_arbiter: RTL and testbench

//  Shares one W-bit parallel load register among N requesters.
//  - Round-robin arbitration picks one requester at a time.
//  - Latches that requester's data and drives load/data_out to the register for exactly one cycle.
//  - Returns a one-cycle ack to the winner.
//  - Sits between the requester blocks and the shared register; it is the only driver of the register's load and data inputs.

---
 rtl/reg_write_arbiter_if.sv | 27 ++
 rtl/reg_write_arbiter.sv | 115 +++++++++++
 tb/tb_reg_write_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Bundle between the requester blocks and the shared-register write arbiter.
// The master side drives requests and data; the slave side is the arbiter.
interface reg_write_arbiter_if #(
    parameter int W = 4,
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic           load;
    logic [W-1:0]   data_out;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic [IW-1:0]  owner;
    logic           busy;

    modport master (
        output req, data_in,
        input  load, data_out, grant, ack, owner, busy
    );

    modport slave (
        input  req, data_in,
        output load, data_out, grant, ack, owner, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that lets N requesters share one W-bit load register,
// issuing a one-cycle load strobe and then a one-cycle ack to the winner.
module reg_write_arbiter #(
    parameter int W = 4,
    parameter int N = 4
) (
    input logic                clk,
    input logic                rst,
    reg_write_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [W-1:0]  data_out_q, data_out_d;
    logic          load_q, load_d;
    logic          busy_q, busy_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] winner_q, winner_d;

    logic          found;
    logic [IW-1:0] pick;
    int            idx;

    // Search starts just after the last winner so it drops to lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = '0;
        data_out_d = data_out_q;
        load_d     = 1'b0;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        winner_d   = winner_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = LOAD;
                    winner_d      = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    data_out_d    = bus.data_in[int'(pick)*W +: W];
                    load_d        = 1'b1;
                end
            end
            LOAD: begin
                state_d         = DONE;
                ack_d[winner_q] = 1'b1;
                owner_d         = winner_q;
                rr_ptr_d        = winner_q;
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            data_out_q <= '0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            rr_ptr_q   <= IW'(N-1);
            winner_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            data_out_q <= data_out_d;
            load_q     <= load_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            winner_q   <= winner_d;
        end
    end

    assign bus.load     = load_q;
    assign bus.data_out = data_out_q;
    assign bus.grant    = grant_q;
    assign bus.ack      = ack_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: reset, single write, round-robin order,
// wrap-around priority, early request drop and reset in the middle of a write.
module tb_reg_write_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    logic [3:0] shared_reg;

    reg_write_arbiter_if #(.W(4), .N(4)) bus ();

    reg_write_arbiter #(.W(4), .N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared register the arbiter writes into.
    always @(posedge clk) begin
        if (rst) shared_reg <= 4'h0;
        else if (bus.load) shared_reg <= bus.data_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.data_in = 16'h4321;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (bus.load !== 1'b0) $display("[TB] FAIL reset_load: got %b want 0", bus.load); else passed++;
            total++; if (bus.grant !== 4'b0000) $display("[TB] FAIL reset_grant: got %b want 0000", bus.grant); else passed++;
            total++; if (bus.ack !== 4'b0000) $display("[TB] FAIL reset_ack: got %b want 0000", bus.ack); else passed++;
            total++; if (bus.owner !== 2'd0) $display("[TB] FAIL reset_owner: got %0d want 0", bus.owner); else passed++;
            total++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        end
        total++; if (bus.data_out !== 4'h0) $display("[TB] FAIL reset_data_out: got %h want 0", bus.data_out); else passed++;
        rst = 1'b0;
        bus.req = 4'b0000;
        tick();
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_idle_busy: got %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_single_write();
        bus.data_in[2*4 +: 4] = 4'hA;
        bus.req = 4'b0100;
        tick();
        total++; if (bus.load !== 1'b1) $display("[TB] FAIL single_load: got %b want 1", bus.load); else passed++;
        total++; if (bus.data_out !== 4'hA) $display("[TB] FAIL single_data: got %h want a", bus.data_out); else passed++;
        total++; if (bus.grant !== 4'b0100) $display("[TB] FAIL single_grant: got %b want 0100", bus.grant); else passed++;
        total++; if (bus.ack !== 4'b0000) $display("[TB] FAIL single_ack_early: got %b want 0000", bus.ack); else passed++;
        total++; if (bus.busy !== 1'b1) $display("[TB] FAIL single_busy: got %b want 1", bus.busy); else passed++;
        tick();
        total++; if (bus.ack !== 4'b0100) $display("[TB] FAIL single_ack: got %b want 0100", bus.ack); else passed++;
        total++; if (bus.load !== 1'b0) $display("[TB] FAIL single_load_done: got %b want 0", bus.load); else passed++;
        total++; if (bus.owner !== 2'd2) $display("[TB] FAIL single_owner: got %0d want 2", bus.owner); else passed++;
        total++; if (shared_reg !== 4'hA) $display("[TB] FAIL single_reg: got %h want a", shared_reg); else passed++;
        bus.req = 4'b0000;
        tick();
        total++; if (bus.ack !== 4'b0000) $display("[TB] FAIL single_ack_clear: got %b want 0000", bus.ack); else passed++;
        total++; if (bus.grant !== 4'b0000) $display("[TB] FAIL single_grant_clear: got %b want 0000", bus.grant); else passed++;
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL single_busy_clear: got %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        logic [3:0] exp_data;
        int         exp_idx;
        rst = 1'b1;
        bus.req = 4'b0000;
        tick();
        rst = 1'b0;
        bus.data_in = {4'h4, 4'h3, 4'h2, 4'h1};
        bus.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_idx  = t % 4;
            exp_oh   = 4'b0001 << exp_idx;
            exp_data = 4'(exp_idx + 1);
            tick();
            total++; if (bus.load !== 1'b1 || bus.grant !== exp_oh) $display("[TB] FAIL rr_load_%0d: got load=%b grant=%b want load=1 grant=%b", t, bus.load, bus.grant, exp_oh); else passed++;
            total++; if (bus.data_out !== exp_data) $display("[TB] FAIL rr_data_%0d: got %h want %h", t, bus.data_out, exp_data); else passed++;
            tick();
            total++; if (bus.ack !== exp_oh) $display("[TB] FAIL rr_ack_%0d: got %b want %b", t, bus.ack, exp_oh); else passed++;
            total++; if (bus.owner !== 2'(exp_idx)) $display("[TB] FAIL rr_owner_%0d: got %0d want %0d", t, bus.owner, exp_idx); else passed++;
            total++; if (shared_reg !== exp_data) $display("[TB] FAIL rr_reg_%0d: got %h want %h", t, shared_reg, exp_data); else passed++;
            tick();
            total++; if (bus.ack !== 4'b0000 || bus.load !== 1'b0) $display("[TB] FAIL rr_gap_%0d: got ack=%b load=%b want 0000/0", t, bus.ack, bus.load); else passed++;
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_wrap_priority();
        bus.req = 4'b1000;
        tick();
        total++; if (bus.grant !== 4'b1000) $display("[TB] FAIL wrap_pre_grant: got %b want 1000", bus.grant); else passed++;
        tick();
        total++; if (bus.owner !== 2'd3) $display("[TB] FAIL wrap_pre_owner: got %0d want 3", bus.owner); else passed++;
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b1001;
        tick();
        total++; if (bus.grant !== 4'b0001) $display("[TB] FAIL wrap_first_grant: got %b want 0001", bus.grant); else passed++;
        total++; if (bus.data_out !== 4'h1) $display("[TB] FAIL wrap_first_data: got %h want 1", bus.data_out); else passed++;
        tick();
        total++; if (bus.ack !== 4'b0001) $display("[TB] FAIL wrap_first_ack: got %b want 0001", bus.ack); else passed++;
        tick();
        tick();
        total++; if (bus.grant !== 4'b1000) $display("[TB] FAIL wrap_second_grant: got %b want 1000", bus.grant); else passed++;
        total++; if (bus.data_out !== 4'h4) $display("[TB] FAIL wrap_second_data: got %h want 4", bus.data_out); else passed++;
        tick();
        total++; if (bus.ack !== 4'b1000 || bus.owner !== 2'd3) $display("[TB] FAIL wrap_second_ack: got ack=%b owner=%0d want 1000/3", bus.ack, bus.owner); else passed++;
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_early_drop();
        bus.data_in[1*4 +: 4] = 4'h5;
        bus.req = 4'b0010;
        tick();
        total++; if (bus.load !== 1'b1 || bus.data_out !== 4'h5) $display("[TB] FAIL drop_load: got load=%b data=%h want 1/5", bus.load, bus.data_out); else passed++;
        bus.req = 4'b0000;
        bus.data_in[1*4 +: 4] = 4'hC;
        tick();
        total++; if (bus.ack !== 4'b0010) $display("[TB] FAIL drop_ack: got %b want 0010", bus.ack); else passed++;
        total++; if (shared_reg !== 4'h5) $display("[TB] FAIL drop_reg: got %h want 5", shared_reg); else passed++;
        tick();
        total++; if (bus.data_out !== 4'h5 || bus.busy !== 1'b0) $display("[TB] FAIL drop_hold: got data=%h busy=%b want 5/0", bus.data_out, bus.busy); else passed++;
        total++; if (bus.owner !== 2'd1) $display("[TB] FAIL drop_owner: got %0d want 1", bus.owner); else passed++;
    endtask

    task automatic test_reset_mid_op();
        bus.req = 4'b0110;
        tick();
        total++; if (bus.load !== 1'b1 || bus.grant !== 4'b0100) $display("[TB] FAIL midrst_load: got load=%b grant=%b want 1/0100", bus.load, bus.grant); else passed++;
        rst = 1'b1;
        tick();
        total++; if (bus.load !== 1'b0) $display("[TB] FAIL midrst_load_cleared: got %b want 0", bus.load); else passed++;
        total++; if (bus.ack !== 4'b0000) $display("[TB] FAIL midrst_ack: got %b want 0000", bus.ack); else passed++;
        total++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) $display("[TB] FAIL midrst_idle: got grant=%b busy=%b want 0000/0", bus.grant, bus.busy); else passed++;
        total++; if (shared_reg !== 4'h0) $display("[TB] FAIL midrst_reg: got %h want 0", shared_reg); else passed++;
        rst = 1'b0;
        bus.req = 4'b0101;
        tick();
        total++; if (bus.grant !== 4'b0001) $display("[TB] FAIL midrst_after_grant: got %b want 0001", bus.grant); else passed++;
        tick();
        total++; if (bus.ack !== 4'b0001 || bus.owner !== 2'd0) $display("[TB] FAIL midrst_after_ack: got ack=%b owner=%0d want 0001/0", bus.ack, bus.owner); else passed++;
        bus.req = 4'b0000;
        tick();
        total++; if (bus.grant !== 4'b0000) $display("[TB] FAIL midrst_final_grant: got %b want 0000", bus.grant); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.data_in = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_wrap_priority();
        test_early_drop();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
